// File: rtl/qspi_mem_arbiter.sv
// Round-robin arbiter in front of the shared QSPI XIP memory controller.
// One transaction is in flight at a time. The granted request is registered
// onto the s_* port and a watchdog turns a stalled controller into a
// one-cycle error pulse back to the granted master.
module qspi_mem_arbiter #(
    parameter int unsigned NUM_REQ     = 6,
    parameter int unsigned ADR_W       = 24,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                     clk_i,
    input  logic                     rst_in,
    input  logic [NUM_REQ-1:0]       en_i,
    input  logic [NUM_REQ-1:0]       m_stb_i,
    input  logic [NUM_REQ-1:0]       m_we_i,
    input  logic [NUM_REQ*ADR_W-1:0] m_adr_i,
    input  logic [NUM_REQ*32-1:0]    m_dat_i,
    input  logic [NUM_REQ*4-1:0]     m_sel_i,
    output logic [31:0]              m_dat_o,
    output logic [NUM_REQ-1:0]       m_ack_o,
    output logic [NUM_REQ-1:0]       m_err_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [ADR_W-1:0]         s_adr_o,
    output logic [31:0]              s_dat_o,
    output logic [3:0]               s_sel_o,
    input  logic [31:0]              s_dat_i,
    input  logic                     s_ack_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic                     busy_o
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    logic [0:0]         state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt_q;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_REQ-1:0] elig;
    logic               pick_vld;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   cand_idx;
    logic [31:0]        cand;

    logic               in_busy;
    logic               done_ack;
    logic               done_err;
    logic               done;

    assign elig     = m_stb_i & en_i;
    assign in_busy  = (state == ST_BUSY);
    // An ack in the same cycle the watchdog expires takes priority over the error.
    assign done_ack = in_busy && s_ack_i;
    assign done_err = in_busy && !s_ack_i && (cnt == CNT_LIMIT);
    assign done     = done_ack || done_err;

    assign m_ack_o  = done_ack ? gnt_q : '0;
    assign m_err_o  = done_err ? gnt_q : '0;
    assign m_dat_o  = s_dat_i;
    assign gnt_o    = gnt_q;
    assign busy_o   = in_busy;

    // Pick the first eligible requester at or above ptr, wrapping at NUM_REQ-1.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!pick_vld && elig[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    // Arbitration state, grant vector and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state   <= ST_IDLE;
            gnt_q   <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
            s_stb_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state   <= ST_BUSY;
                        gnt_q   <= NUM_REQ'(1) << pick_idx;
                        gnt_idx <= pick_idx;
                        s_stb_o <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (done) begin
                        state   <= ST_IDLE;
                        gnt_q   <= '0;
                        s_stb_o <= 1'b0;
                        ptr     <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    gnt_q   <= '0;
                    s_stb_o <= 1'b0;
                end
            endcase
        end
    end

    // Capture the winner's request fields; they are held for the whole transaction.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            s_we_o  <= 1'b0;
            s_adr_o <= '0;
            s_dat_o <= '0;
            s_sel_o <= '0;
        end else if (state == ST_IDLE && pick_vld) begin
            s_we_o  <= m_we_i[pick_idx];
            s_adr_o <= m_adr_i[pick_idx*ADR_W +: ADR_W];
            s_dat_o <= m_dat_i[pick_idx*32 +: 32];
            s_sel_o <= m_sel_i[pick_idx*4 +: 4];
        end
    end

    // Watchdog: cleared on grant, counts BUSY cycles, saturates at the limit.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cnt <= '0;
        end else if (state == ST_IDLE) begin
            cnt <= '0;
        end else if (!done && cnt != CNT_LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// Self-checking bench for qspi_mem_arbiter (6 requesters, 24-bit addresses,
// watchdog limit 8). Expected grants come from a rotate-and-find-lowest
// model of the round-robin rule; the bench plays the QSPI controller.
module tb_qspi_mem_arbiter;

    localparam int NREQ = 6;
    localparam int AW   = 24;
    localparam int TO   = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic [NREQ-1:0]      en, stb, we;
    logic [NREQ*AW-1:0]   adr_bus;
    logic [NREQ*32-1:0]   dat_bus;
    logic [NREQ*4-1:0]    sel_bus;
    logic [31:0]          m_dat;
    logic [NREQ-1:0]      m_ack, m_err, gnt;
    logic                 s_stb, s_we, s_ack, busy;
    logic [AW-1:0]        s_adr;
    logic [31:0]          s_dat_o, s_dat_i;
    logic [3:0]           s_sel;

    logic [AW-1:0] a_adr [NREQ];
    logic [31:0]   a_dat [NREQ];
    logic [3:0]    a_sel [NREQ];

    int checks   = 0;
    int failures = 0;
    int mptr     = 0;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic            stb;
        logic            we;
        logic [AW-1:0]   adr;
        logic [31:0]     dat;
        logic [3:0]      sel;
        logic [NREQ-1:0] ack;
        logic [NREQ-1:0] err;
        logic [31:0]     mdat;
        bit              early;
        bit              unstable;
        logic            busy_after;
        logic            stb_after;
        logic [NREQ-1:0] gnt_after;
        logic [NREQ-1:0] pulse_after;
    } obs_t;

    qspi_mem_arbiter #(
        .NUM_REQ    (NREQ),
        .ADR_W      (AW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i  (clk),
        .rst_in (rst_n),
        .en_i   (en),
        .m_stb_i(stb),
        .m_we_i (we),
        .m_adr_i(adr_bus),
        .m_dat_i(dat_bus),
        .m_sel_i(sel_bus),
        .m_dat_o(m_dat),
        .m_ack_o(m_ack),
        .m_err_o(m_err),
        .s_stb_o(s_stb),
        .s_we_o (s_we),
        .s_adr_o(s_adr),
        .s_dat_o(s_dat_o),
        .s_sel_o(s_sel),
        .s_dat_i(s_dat_i),
        .s_ack_i(s_ack),
        .gnt_o  (gnt),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    // Round-robin rule: rotate elig right by p, take the lowest set bit.
    function automatic int rr_pick(input logic [NREQ-1:0] e, input int p);
        logic [2*NREQ-1:0] d;
        logic [NREQ-1:0]   r;
        logic [NREQ-1:0]   low;
        if (e == '0) return -1;
        d   = {e, e} >> p;
        r   = d[NREQ-1:0];
        low = r & (~r + 6'd1);
        return (p + $clog2(low)) % NREQ;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int idx);
        return NREQ'(1) << idx;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack();
        for (int i = 0; i < NREQ; i++) begin
            adr_bus[i*AW +: AW] = a_adr[i];
            dat_bus[i*32 +: 32] = a_dat[i];
            sel_bus[i*4 +: 4]   = a_sel[i];
        end
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < NREQ; i++) begin
            a_adr[i] = AW'($urandom);
            a_dat[i] = $urandom;
            a_sel[i] = 4'($urandom);
        end
        we = NREQ'($urandom);
        pack();
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        s_ack   = 1'b0;
        s_dat_i = '0;
        en      = '0;
        stb     = '0;
        randomize_fields();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        mptr = 0;
    endtask

    // Plays the controller for one transaction: the bench is in an IDLE cycle
    // with requests already driven. Ack comes lat cycles after s_stb_o rises
    // (never if lat > TO). Returns what the DUT showed; callers judge it.
    task automatic run_txn(input int lat, input logic [31:0] rdat, input bit drop_req, output obs_t o);
        int last;
        last       = (lat < TO) ? lat : TO;
        o.early    = 1'b0;
        o.unstable = 1'b0;
        o.ack      = '0;
        o.err      = '0;
        o.mdat     = '0;
        step();
        for (int k = 0; k <= last; k++) begin
            if (k > 0) step();
            s_ack   = (k == lat);
            s_dat_i = (k == lat) ? rdat : $urandom;
            if (k == 1) begin
                randomize_fields();
                if (drop_req) begin
                    en  = '0;
                    stb = '0;
                end
            end
            #1;
            if (k == 0) begin
                o.gnt = gnt;
                o.stb = s_stb;
                o.we  = s_we;
                o.adr = s_adr;
                o.dat = s_dat_o;
                o.sel = s_sel;
            end else if (s_we !== o.we || s_adr !== o.adr || s_dat_o !== o.dat || s_sel !== o.sel) begin
                o.unstable = 1'b1;
            end
            if (k == last) begin
                o.ack  = m_ack;
                o.err  = m_err;
                o.mdat = m_dat;
            end else if (m_ack !== '0 || m_err !== '0 || s_stb !== 1'b1) begin
                o.early = 1'b1;
            end
        end
        step();
        s_ack = 1'b0;
        #1;
        o.busy_after  = busy;
        o.stb_after   = s_stb;
        o.gnt_after   = gnt;
        o.pulse_after = m_ack | m_err;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_ack   = 1'b1;
        s_dat_i = '0;
        en      = '1;
        stb     = '1;
        randomize_fields();
        #1;
        checks++; if (s_stb !== 1'b0) begin failures++; $display("FAIL reset_s_stb got=%b exp=0", s_stb); end
        checks++; if (gnt !== '0 || busy !== 1'b0) begin failures++; $display("FAIL reset_gnt_busy got=%b/%b exp=0/0", gnt, busy); end
        checks++; if ((m_ack | m_err) !== '0) begin failures++; $display("FAIL reset_ack_err got=%b/%b exp=0", m_ack, m_err); end
        checks++; if ({s_we, s_adr, s_dat_o, s_sel} !== '0) begin failures++; $display("FAIL reset_s_fields got=%b/%h/%h/%h exp=0", s_we, s_adr, s_dat_o, s_sel); end
        repeat (3) step();
        checks++; if (gnt !== '0 || s_stb !== 1'b0) begin failures++; $display("FAIL reset_held got gnt=%b stb=%b exp=0", gnt, s_stb); end
        s_ack = 1'b0;
        stb   = '0;
        rst_n = 1'b1;
        step();
        mptr = 0;
    endtask

    task automatic test_single();
        obs_t o;
        apply_reset();
        en       = '1;
        a_adr[2] = 24'h000100;
        we[2]    = 1'b0;
        pack();
        stb      = 6'b000100;
        #1;
        checks++; if (s_stb !== 1'b0) begin failures++; $display("FAIL single_cycle0_stb got=%b exp=0", s_stb); end
        // Requester drops en and stb mid-transaction; it must still be acked.
        run_txn(4, 32'hDEADBEEF, 1'b1, o);
        checks++; if (o.stb !== 1'b1 || o.gnt !== 6'b000100) begin failures++; $display("FAIL single_issue got stb=%b gnt=%b exp stb=1 gnt=000100", o.stb, o.gnt); end
        checks++; if (o.adr !== 24'h000100 || o.we !== 1'b0) begin failures++; $display("FAIL single_fields got adr=%h we=%b exp adr=000100 we=0", o.adr, o.we); end
        checks++; if (o.ack !== 6'b000100 || o.err !== '0) begin failures++; $display("FAIL single_ack got ack=%b err=%b exp ack=000100 err=0", o.ack, o.err); end
        checks++; if (o.mdat !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rdata got=%h exp=deadbeef", o.mdat); end
        checks++; if (o.early || o.unstable) begin failures++; $display("FAIL single_busy_phase got early=%0d unstable=%0d exp 0/0", o.early, o.unstable); end
        checks++; if (o.busy_after !== 1'b0 || o.stb_after !== 1'b0) begin failures++; $display("FAIL single_teardown got busy=%b stb=%b exp 0/0", o.busy_after, o.stb_after); end
        mptr = 3;
        en   = '1;
    endtask

    task automatic test_round_robin();
        obs_t o;
        int exp;
        int served [NREQ];
        logic [AW-1:0] e_adr;
        logic [31:0]   e_dat, rdat;
        logic [3:0]    e_sel;
        logic          e_we;
        apply_reset();
        en  = '1;
        stb = '1;
        foreach (served[i]) served[i] = 0;
        for (int t = 0; t < 2 * NREQ; t++) begin
            randomize_fields();
            exp   = rr_pick(stb & en, mptr);
            e_adr = a_adr[exp];
            e_dat = a_dat[exp];
            e_sel = a_sel[exp];
            e_we  = we[exp];
            rdat  = $urandom;
            run_txn(2, rdat, 1'b0, o);
            checks++; if (o.gnt !== onehot(exp)) begin failures++; $display("FAIL rr_gnt t=%0d got=%b exp=%b", t, o.gnt, onehot(exp)); end
            checks++; if (o.adr !== e_adr || o.dat !== e_dat || o.sel !== e_sel || o.we !== e_we) begin failures++; $display("FAIL rr_fields t=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", t, o.adr, o.dat, o.sel, o.we, e_adr, e_dat, e_sel, e_we); end
            checks++; if (o.ack !== onehot(exp) || o.err !== '0 || o.mdat !== rdat) begin failures++; $display("FAIL rr_ack t=%0d got ack=%b err=%b dat=%h exp ack=%b err=0 dat=%h", t, o.ack, o.err, o.mdat, onehot(exp), rdat); end
            checks++; if (o.early || o.unstable || o.busy_after !== 1'b0) begin failures++; $display("FAIL rr_phase t=%0d got early=%0d unstable=%0d busy_after=%b exp 0/0/0", t, o.early, o.unstable, o.busy_after); end
            for (int i = 0; i < NREQ; i++) if (o.gnt[i] === 1'b1) served[i]++;
            mptr = (exp + 1) % NREQ;
        end
        for (int i = 0; i < NREQ; i++) begin
            checks++; if (served[i] != 2) begin failures++; $display("FAIL rr_fairness req=%0d got=%0d exp=2", i, served[i]); end
        end
    endtask

    task automatic test_enable_mask();
        obs_t o;
        int exp;
        logic [NREQ-1:0] stray;
        apply_reset();
        en    = 6'b101010;
        stb   = '1;
        stray = '0;
        for (int t = 0; t < 6; t++) begin
            randomize_fields();
            exp = rr_pick(stb & en, mptr);
            run_txn($urandom_range(0, 3), $urandom, 1'b0, o);
            checks++; if (o.gnt !== onehot(exp) || o.ack !== onehot(exp)) begin failures++; $display("FAIL mask_gnt t=%0d got gnt=%b ack=%b exp=%b", t, o.gnt, o.ack, onehot(exp)); end
            stray |= (o.gnt | o.ack | o.err | o.gnt_after | o.pulse_after) & 6'b010101;
            if (o.early) stray |= 6'b111111;
            mptr = (exp + 1) % NREQ;
        end
        checks++; if (stray !== '0) begin failures++; $display("FAIL mask_disabled_activity got=%b exp=000000", stray); end
    endtask

    task automatic test_timeout();
        obs_t o;
        apply_reset();
        en  = '1;
        stb = 6'b110000;
        run_txn(1000, '0, 1'b0, o);
        checks++; if (o.gnt !== 6'b010000) begin failures++; $display("FAIL timeout_gnt got=%b exp=010000", o.gnt); end
        checks++; if (o.err !== 6'b010000 || o.ack !== '0) begin failures++; $display("FAIL timeout_err got err=%b ack=%b exp err=010000 ack=0", o.err, o.ack); end
        checks++; if (o.early) begin failures++; $display("FAIL timeout_early got=1 exp=0"); end
        checks++; if (o.stb_after !== 1'b0 || o.busy_after !== 1'b0) begin failures++; $display("FAIL timeout_teardown got stb=%b busy=%b exp 0/0", o.stb_after, o.busy_after); end
        mptr = 5;
        // Requester 4 drops after its error; a spurious controller ack arrives in IDLE.
        stb   = 6'b100000;
        s_ack = 1'b1;
        #1;
        checks++; if (m_ack !== '0 || m_err !== '0) begin failures++; $display("FAIL spurious_ack got ack=%b err=%b exp 0", m_ack, m_err); end
        run_txn(1, 32'h12345678, 1'b0, o);
        checks++; if (o.gnt !== onehot(rr_pick(stb & en, mptr)) || o.ack !== 6'b100000) begin failures++; $display("FAIL timeout_next_gnt got gnt=%b ack=%b exp=100000", o.gnt, o.ack); end
        mptr = 0;
    endtask

    task automatic test_collision();
        obs_t o;
        stb = 6'b001000;
        run_txn(TO, 32'hA5A5_0F0F, 1'b0, o);
        checks++; if (o.gnt !== 6'b001000) begin failures++; $display("FAIL collision_gnt got=%b exp=001000", o.gnt); end
        checks++; if (o.ack !== 6'b001000 || o.err !== '0 || o.mdat !== 32'hA5A5_0F0F) begin failures++; $display("FAIL collision_ack got ack=%b err=%b dat=%h exp ack=001000 err=0 dat=a5a50f0f", o.ack, o.err, o.mdat); end
        checks++; if (o.early || o.busy_after !== 1'b0) begin failures++; $display("FAIL collision_phase got early=%0d busy_after=%b exp 0/0", o.early, o.busy_after); end
        mptr = 4;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        apply_reset();
        en  = '1;
        stb = 6'b001000;
        run_txn(1, $urandom, 1'b0, o);
        stb = 6'b010000;
        step();
        repeat (3) step();
        s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if (s_stb !== 1'b0 || busy !== 1'b0 || gnt !== '0) begin failures++; $display("FAIL resetmid_outputs got stb=%b busy=%b gnt=%b exp 0", s_stb, busy, gnt); end
        checks++; if (m_ack !== '0 || m_err !== '0) begin failures++; $display("FAIL resetmid_ack_err got ack=%b err=%b exp 0", m_ack, m_err); end
        step();
        rst_n = 1'b1;
        s_ack = 1'b0;
        stb   = '1;
        #1;
        step();
        checks++; if (gnt !== 6'b000001 || s_stb !== 1'b1) begin failures++; $display("FAIL resetmid_ptr got gnt=%b stb=%b exp gnt=000001 stb=1", gnt, s_stb); end
    endtask

    task automatic test_random();
        obs_t o;
        int exp, lat, r;
        logic [AW-1:0] e_adr;
        logic [31:0]   e_dat, rdat;
        logic [3:0]    e_sel;
        logic          e_we;
        apply_reset();
        for (int t = 0; t < 30; t++) begin
            en  = NREQ'($urandom);
            stb = NREQ'($urandom);
            if ((en & stb) == '0) begin
                r      = $urandom_range(0, NREQ - 1);
                en[r]  = 1'b1;
                stb[r] = 1'b1;
            end
            randomize_fields();
            exp   = rr_pick(stb & en, mptr);
            e_adr = a_adr[exp];
            e_dat = a_dat[exp];
            e_sel = a_sel[exp];
            e_we  = we[exp];
            lat   = $urandom_range(0, TO + 3);
            rdat  = $urandom;
            run_txn(lat, rdat, 1'b0, o);
            checks++; if (o.gnt !== onehot(exp) || o.stb !== 1'b1) begin failures++; $display("FAIL rand_gnt t=%0d got=%b stb=%b exp=%b", t, o.gnt, o.stb, onehot(exp)); end
            checks++; if (o.adr !== e_adr || o.dat !== e_dat || o.sel !== e_sel || o.we !== e_we) begin failures++; $display("FAIL rand_fields t=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", t, o.adr, o.dat, o.sel, o.we, e_adr, e_dat, e_sel, e_we); end
            if (lat <= TO) begin
                checks++; if (o.ack !== onehot(exp) || o.err !== '0 || o.mdat !== rdat) begin failures++; $display("FAIL rand_ack t=%0d lat=%0d got ack=%b err=%b dat=%h exp ack=%b dat=%h", t, lat, o.ack, o.err, o.mdat, onehot(exp), rdat); end
            end else begin
                checks++; if (o.err !== onehot(exp) || o.ack !== '0) begin failures++; $display("FAIL rand_err t=%0d got err=%b ack=%b exp err=%b", t, o.err, o.ack, onehot(exp)); end
            end
            checks++; if (o.early || o.unstable || o.busy_after !== 1'b0 || o.pulse_after !== '0) begin failures++; $display("FAIL rand_phase t=%0d got early=%0d unstable=%0d busy=%b pulse=%b exp 0", t, o.early, o.unstable, o.busy_after, o.pulse_after); end
            mptr = (exp + 1) % NREQ;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_enable_mask();
        test_timeout();
        test_collision();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/qspi_mem_arbiter.md
# qspi_mem_arbiter

Round-robin arbiter sharing the single QSPI XIP memory controller (ROM/RAM behind `qspi_mem_*` pads) among the SoC's bus masters: Wishbone host, peripheral masters and the FazyRV core variants. It sits between the master-side ports and the QSPI memory controller. Requesters whose chip-level enable strap (`en_*` pins) is low are never granted. A per-transaction watchdog returns an error to the master if the controller stalls.

## Interface
- `NUM_REQ`, default 6: number of requesters, ≥2.
- `ADR_W`, default 24: byte address width.
- `TIMEOUT_CYC`, default 1023: maximum cycles a granted transaction waits for `s_ack_i`. Range 1..65535.

- `clk_i`, input, 1: clock, rising edge.
- `rst_in`, input, 1: asynchronous active-low reset.
- `en_i`, input, NUM_REQ: per-requester enable. Bit i corresponds to requester i.
- `m_stb_i`, input, NUM_REQ: request strobe. Held high until ack or err.
- `m_we_i`, input, NUM_REQ: write enable.
- `m_adr_i`, input, NUM_REQ*ADR_W: addresses, requester i at slice [i*ADR_W +: ADR_W].
- `m_dat_i`, input, NUM_REQ*32: write data, same slicing scheme.
- `m_sel_i`, input, NUM_REQ*4: byte selects, same slicing scheme.
- `m_dat_o`, output, 32: read data, broadcast to all requesters. Valid only with that requester's `m_ack_o`.
- `m_ack_o`, output, NUM_REQ: completion, one-hot, 1-cycle pulse.
- `m_err_o`, output, NUM_REQ: timeout error, one-hot, 1-cycle pulse.
- `s_stb_o`, output, 1: request to the QSPI memory controller.
- `s_we_o`, `s_adr_o`, `s_dat_o`, `s_sel_o`, outputs, 1/ADR_W/32/4: registered copy of the granted request.
- `s_dat_i`, input, 32: controller read data.
- `s_ack_i`, input, 1: controller completion, 1-cycle pulse.
- `gnt_o`, output, NUM_REQ: current one-hot grant, for debug/observability.
- `busy_o`, output, 1: high in state BUSY.

## Operation
- States: IDLE, BUSY.
- Eligible requesters: `elig = m_stb_i & en_i`.
- IDLE:
  - If `elig != 0`, select the first set bit of `elig` searching upward from `ptr`, wrapping from NUM_REQ-1 to 0.
  - Register `gnt_o` and capture that requester's we/adr/dat/sel into the `s_*` registers.
  - Set `s_stb_o=1`, clear the timeout counter, go to BUSY.
- BUSY, on `s_ack_i=1`:
  - `m_ack_o = gnt_o` (combinational, same cycle); `m_dat_o = s_dat_i` (combinational).
  - Registered at the same edge: `s_stb_o←0`, `gnt_o←0`, `ptr←(granted index+1) mod NUM_REQ`, go to IDLE.
- BUSY, on counter == TIMEOUT_CYC with `s_ack_i=0`:
  - `m_err_o = gnt_o` for that cycle.
  - Same teardown as an ack, including the `ptr` update, go to IDLE.
- BUSY otherwise: counter increments by 1. Counter width is clog2(TIMEOUT_CYC+1). It saturates and never wraps.
- `s_*` request fields stay stable for the whole BUSY period. The requester's inputs are ignored after capture.
- `m_dat_o` equals `s_dat_i` at all times (pure pass-through). Masters sample it only with their own ack.
- Deasserting `en_i[g]` or `m_stb_i[g]` while requester g is granted does not abort the transaction. It still completes and ack/err is still driven to g.
- Disabled requesters (`en_i[i]=0`) never receive a grant. Their `m_ack_o` and `m_err_o` stay 0.

## Timing
- Reset values (asynchronous):
  - Outputs: `s_stb_o=0`, `s_we_o=0`, `s_adr_o=0`, `s_dat_o=0`, `s_sel_o=0`, `gnt_o=0`, `busy_o=0`, `m_ack_o=0`, `m_err_o=0`.
  - Internal: `ptr=0`, counter=0, state IDLE.
- Request-to-issue latency is 1 cycle: `m_stb_i` high in IDLE at cycle n gives `s_stb_o=1` from cycle n+1.
- Turnaround is 1 IDLE cycle between transactions. The next grant is evaluated in the cycle after ack/err, so peak throughput is one transaction per (controller latency + 2) cycles.
- `s_ack_i` arriving in the same cycle the counter reaches TIMEOUT_CYC: ack wins, no err.
- `s_ack_i` seen in IDLE (spurious) is ignored and produces no `m_ack_o`.
- Reset asserted mid-transaction:
  - `s_stb_o` drops immediately (asynchronously) and state returns to IDLE.
  - The QSPI controller is reset by the same `rst_in`.
- Fairness: with all NUM_REQ requesters continuously eligible, each is served exactly once per NUM_REQ transactions.

## Test plan
- Single request: req 2 asserts stb with we=0, adr=0x000100 at cycle 0. Expect `s_stb_o` and `gnt_o`=6'b000100 at cycle 1. Controller acks at cycle 5 with data 0xDEADBEEF. Expect `m_ack_o`=6'b000100 and `m_dat_o`=0xDEADBEEF at cycle 5, and `busy_o`=0 at cycle 6.
- Round-robin: all 6 requesters stb high continuously, all en=1, controller acks 2 cycles after each `s_stb_o` rise. Expect grant order 0,1,2,3,4,5,0, with each `s_adr_o` matching the granted slice.
- Enable mask: en_i=6'b101010, all stb high. Expect grants only to 1,3,5,1,…, and zero acks on requesters 0, 2 and 4.
- Timeout: TIMEOUT_CYC=8, requester 4 granted, controller never acks. Expect `m_err_o[4]` pulse exactly 8 cycles after `s_stb_o` rise, `s_stb_o` low the next cycle, and the next grant going to requester 5 if it is requesting.
- Ack/timeout collision: `s_ack_i` arrives on the cycle the counter reaches TIMEOUT_CYC. Expect `m_ack_o` pulse only, with no `m_err_o`.
- Reset mid-transaction: assert `rst_in` low 3 cycles into BUSY. Expect all outputs 0 immediately. After release, a new request is granted starting from `ptr`=0.
